// File: rtl/interrupt_sequencer.sv
// Prioritised interrupt sequencer: synchronises and edge-detects request lines,
// latches them as pending, selects the lowest-index eligible source and
// requests a divert at the next instruction boundary. Keeps the return PC and
// retires the in-service source on eret.
// Optional feature macro: INT_NEST_EN. When defined, a higher-priority source
// may preempt a running handler and EPC becomes a NUM_SRC-deep stack. When
// undefined, only one handler runs at a time and EPC is a single register.
module interrupt_sequencer #(
  parameter int unsigned NUM_SRC    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
  parameter int unsigned VEC_STRIDE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               global_en,
  input  logic               instr_done,
  input  logic [31:0]        pc_next,
  input  logic               eret,
  output logic               int_req,
  output logic [31:0]        int_vector,
  output logic [31:0]        epc,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);

  localparam int unsigned WW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [WW-1:0]      winner_q, winner_d;
  logic               int_req_q;

  logic [NUM_SRC-1:0] rise, win_onehot, svc_low_q, svc_low_d;
  logic [NUM_SRC-1:0] pend_kept, allowed_d, elig_d;
  logic               do_entry, do_return;

  // Two-flop synchroniser plus a third flop that remembers the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, forming a true shift chain.
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state decode: entry/return events, pending/in-service update, winner.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    rise         = sync2_q & ~sync3_q;
    win_onehot   = NUM_SRC'(1) << winner_q;
    do_entry     = (state_q == ST_REQ) && instr_done && !eret;
    do_return    = instr_done && eret && (in_service_q != '0);
    svc_low_q    = in_service_q & (~in_service_q + NUM_SRC'(1));
    in_service_d = in_service_q;
    pend_kept    = pending_q;
    winner_d     = '0;

    // A return takes precedence; entry is only possible without eret anyway.
    if (do_return) begin
      in_service_d = in_service_q & ~svc_low_q;
    end else if (do_entry) begin
      in_service_d = in_service_q | win_onehot;
      pend_kept    = pending_q & ~win_onehot;
    end

    // A fresh edge on the source being entered survives the clear.
    pending_d = pend_kept | rise;

    svc_low_d = in_service_d & (~in_service_d + NUM_SRC'(1));
`ifdef INT_NEST_EN
    // Only sources strictly above the highest-priority active handler.
    allowed_d = svc_low_d - NUM_SRC'(1);
`else
    allowed_d = (in_service_d == '0) ? '1 : '0;
`endif
    // Freshly latched edges become eligible one edge after they set pending.
    elig_d = pend_kept & mask & allowed_d & {NUM_SRC{global_en}};

    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (elig_d[i]) winner_d = WW'(i);
    end

    if (elig_d != '0)             state_d = ST_REQ;
    else if (in_service_d != '0)  state_d = ST_SERVE;
    else                          state_d = ST_IDLE;
  end

  // FSM, request flags and the registered winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      in_service_q <= '0;
      winner_q     <= '0;
      int_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      winner_q     <= winner_d;
      int_req_q    <= (state_d == ST_REQ);
    end
  end

`ifdef INT_NEST_EN
  localparam int unsigned SPW = $clog2(NUM_SRC + 1);

  logic [SPW-1:0] sp_q;
  logic [31:0]    stack_q [NUM_SRC];

  // Stack pointer: one push per entry, one pop per return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (do_entry) begin
      sp_q <= sp_q + SPW'(1);
    end else if (do_return) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

  // EPC storage written at the current stack pointer on entry.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; sp_q is reset and gates every read,
    // so stale contents are never visible.
    if (do_entry) stack_q[sp_q] <= pc_next;
  end

  assign epc = (sp_q == '0) ? 32'h0 : stack_q[sp_q - SPW'(1)];
`else
  logic [31:0] epc_q;

  // Single return address: captured on entry, cleared on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= '0;
    end else if (do_entry) begin
      epc_q <= pc_next;
    end else if (do_return) begin
      epc_q <= '0;
    end
  end

  assign epc = epc_q;
`endif

  assign int_req    = int_req_q;
  assign int_vector = VEC_BASE + (32'(winner_q) * VEC_STRIDE);
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
